// File: rtl/hazard_control_unit.sv
// Hazard control for the pipelined SAD datapath: load-use stalls, branch flushes,
// ALU operand forwarding, a stall-streak watchdog and saturating event counters.
module hazard_control_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             idex_MemRead,
    input  logic             idex_RegWrite,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             exmem_RegWrite,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_RegWrite,
    input  logic [4:0]       memwb_rd,
    input  logic             ex_PCSrc,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             deadlock,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned FC_W     = 4;
    localparam int unsigned STREAK_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic                 deadlock_q, deadlock_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                 lu_c;
    logic                 flush_now;
    logic                 stall_now;

    // Forwarding select for one ALU operand; EX/MEM is the newer value and wins.
    function automatic logic [1:0] fwd_sel(
        input logic       em_wr,
        input logic [4:0] em_rd,
        input logic       mw_wr,
        input logic [4:0] mw_rd,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (em_wr && (em_rd != 5'd0) && (em_rd == src)) begin
            sel = 2'b10;
        end else if (mw_wr && (mw_rd != 5'd0) && (mw_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Load in EX feeding a register the ID instruction actually reads.
    always_comb begin
        lu_c = id_valid && idex_MemRead && (idex_rd != 5'd0) &&
               ((id_uses_rs && (id_rs == idex_rd)) ||
                (id_uses_rt && (id_rt == idex_rd)));
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        streak_d    = streak_q;
        deadlock_d  = deadlock_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        flush_now   = 1'b0;
        stall_now   = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        ForwardA    = fwd_sel(exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd, ex_rs);
        ForwardB    = fwd_sel(exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd, ex_rt);

        // A taken branch outranks a load-use stall; the flush discards the stalled op anyway.
        case (state_q)
            RUN: begin
                if (ex_PCSrc) begin
                    flush_now = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (lu_c) begin
                    stall_now = 1'b1;
                end
            end
            FLUSH: begin
                flush_now = 1'b1;
                if (fcnt_q == FC_W'(1)) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (flush_now) begin
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end

        if (stall_now) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end

        // Streak of frozen-PC cycles; saturates so the sticky flag can only set once.
        if (stall_now) begin
            if (streak_q < STREAK_W'(MAX_STALL)) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end else begin
            streak_d = '0;
        end
        deadlock_d = deadlock_q || (streak_d >= STREAK_W'(MAX_STALL));

        if (Rst) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
            ForwardA    = 2'b00;
            ForwardB    = 2'b00;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            streak_q    <= '0;
            deadlock_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            streak_q    <= streak_d;
            deadlock_q  <= deadlock_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign deadlock    = deadlock_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
